// File: rtl/mem2axi_pkg.sv
// Shared AXI encodings for the memory-request to AXI4 master bridge.
package mem2axi_pkg;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'b00,
        AXI_BURST_INCR  = 2'b01,
        AXI_BURST_WRAP  = 2'b10
    } axi_burst_e;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_EXOKAY = 2'b01,
        AXI_RESP_SLVERR = 2'b10,
        AXI_RESP_DECERR = 2'b11
    } axi_resp_e;

    localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

    function automatic logic axi_resp_is_err(input logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/mem2axi.sv
// Memory req/gnt/rvalid port to AXI4 master: one single-beat AXI transaction per
// request, one transaction outstanding, response returned on rvalid_o/rdata_o/err_o.
module mem2axi
    import mem2axi_pkg::*;
#(
    parameter int unsigned AXI_ID_WIDTH   = 2,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_USER_WIDTH = 1,
    parameter int unsigned AXI_ID         = 0
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,

    input  logic                        req_i,
    output logic                        gnt_o,
    input  logic                        we_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   addr_i,
    input  logic [AXI_DATA_WIDTH/8-1:0] be_i,
    input  logic [AXI_USER_WIDTH-1:0]   user_i,
    input  logic [AXI_DATA_WIDTH-1:0]   wdata_i,
    output logic                        rvalid_o,
    output logic [AXI_DATA_WIDTH-1:0]   rdata_o,
    output logic                        err_o,

    output logic [AXI_ID_WIDTH-1:0]     master_axi_awid_o,
    output logic [AXI_ADDR_WIDTH-1:0]   master_axi_awaddr_o,
    output logic [7:0]                  master_axi_awlen_o,
    output logic [2:0]                  master_axi_awsize_o,
    output logic [1:0]                  master_axi_awburst_o,
    output logic                        master_axi_awlock_o,
    output logic [3:0]                  master_axi_awcache_o,
    output logic [2:0]                  master_axi_awprot_o,
    output logic [3:0]                  master_axi_awqos_o,
    output logic [3:0]                  master_axi_awregion_o,
    output logic [AXI_USER_WIDTH-1:0]   master_axi_awuser_o,
    output logic                        master_axi_awvalid_o,
    input  logic                        master_axi_awready_i,

    output logic [AXI_DATA_WIDTH-1:0]   master_axi_wdata_o,
    output logic [AXI_DATA_WIDTH/8-1:0] master_axi_wstrb_o,
    output logic                        master_axi_wlast_o,
    output logic [AXI_USER_WIDTH-1:0]   master_axi_wuser_o,
    output logic                        master_axi_wvalid_o,
    input  logic                        master_axi_wready_i,

    input  logic [AXI_ID_WIDTH-1:0]     master_axi_bid_i,
    input  logic [1:0]                  master_axi_bresp_i,
    input  logic [AXI_USER_WIDTH-1:0]   master_axi_buser_i,
    input  logic                        master_axi_bvalid_i,
    output logic                        master_axi_bready_o,

    output logic [AXI_ID_WIDTH-1:0]     master_axi_arid_o,
    output logic [AXI_ADDR_WIDTH-1:0]   master_axi_araddr_o,
    output logic [7:0]                  master_axi_arlen_o,
    output logic [2:0]                  master_axi_arsize_o,
    output logic [1:0]                  master_axi_arburst_o,
    output logic                        master_axi_arlock_o,
    output logic [3:0]                  master_axi_arcache_o,
    output logic [2:0]                  master_axi_arprot_o,
    output logic [3:0]                  master_axi_arqos_o,
    output logic [3:0]                  master_axi_arregion_o,
    output logic [AXI_USER_WIDTH-1:0]   master_axi_aruser_o,
    output logic                        master_axi_arvalid_o,
    input  logic                        master_axi_arready_i,

    input  logic [AXI_ID_WIDTH-1:0]     master_axi_rid_i,
    input  logic [AXI_DATA_WIDTH-1:0]   master_axi_rdata_i,
    input  logic [1:0]                  master_axi_rresp_i,
    input  logic                        master_axi_rlast_i,
    input  logic [AXI_USER_WIDTH-1:0]   master_axi_ruser_i,
    input  logic                        master_axi_rvalid_i,
    output logic                        master_axi_rready_o
);

    localparam int unsigned NR_BYTES     = AXI_DATA_WIDTH / 8;
    localparam int unsigned LOG_NR_BYTES = $clog2(NR_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WAIT_B,
        READ,
        WAIT_R
    } state_e;

    state_e                      state_q,    state_d;
    logic [AXI_ADDR_WIDTH-1:0]   addr_q,     addr_d;
    logic [NR_BYTES-1:0]         be_q,       be_d;
    logic [AXI_DATA_WIDTH-1:0]   wdata_q,    wdata_d;
    logic [AXI_USER_WIDTH-1:0]   user_q,     user_d;
    logic                        aw_valid_q, aw_valid_d;
    logic                        w_valid_q,  w_valid_d;
    logic                        ar_valid_q, ar_valid_d;
    logic                        rvalid_q,   rvalid_d;
    logic [AXI_DATA_WIDTH-1:0]   rdata_q,    rdata_d;
    logic                        err_q,      err_d;

    logic aw_done;
    logic w_done;

    // A channel is done once its valid is down or is being accepted this cycle.
    assign aw_done = !aw_valid_q || master_axi_awready_i;
    assign w_done  = !w_valid_q  || master_axi_wready_i;

    // Grant is combinational in IDLE; held low while reset is asserted.
    assign gnt_o = rst_ni && (state_q == IDLE) && req_i;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path infers a latch.
        state_d    = state_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        user_d     = user_q;
        aw_valid_d = aw_valid_q;
        w_valid_d  = w_valid_q;
        ar_valid_d = ar_valid_q;
        rvalid_d   = 1'b0;
        rdata_d    = rdata_q;
        err_d      = err_q;

        unique case (state_q)
            IDLE: begin
                if (req_i) begin
                    addr_d  = addr_i;
                    be_d    = be_i;
                    wdata_d = wdata_i;
                    user_d  = user_i;
                    if (we_i) begin
                        state_d    = WRITE;
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                    end else begin
                        state_d    = READ;
                        ar_valid_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (aw_valid_q && master_axi_awready_i) aw_valid_d = 1'b0;
                if (w_valid_q && master_axi_wready_i)   w_valid_d  = 1'b0;
                if (aw_done && w_done)                  state_d    = WAIT_B;
            end
            WAIT_B: begin
                if (master_axi_bvalid_i) begin
                    rvalid_d = 1'b1;
                    err_d    = axi_resp_is_err(master_axi_bresp_i);
                    state_d  = IDLE;
                end
            end
            READ: begin
                if (master_axi_arready_i) begin
                    ar_valid_d = 1'b0;
                    state_d    = WAIT_R;
                end
            end
            WAIT_R: begin
                if (master_axi_rvalid_i) begin
                    rvalid_d = 1'b1;
                    rdata_d  = master_axi_rdata_i;
                    err_d    = axi_resp_is_err(master_axi_rresp_i);
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            user_q     <= '0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            ar_valid_q <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q    <= state_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            user_q     <= user_d;
            aw_valid_q <= aw_valid_d;
            w_valid_q  <= w_valid_d;
            ar_valid_q <= ar_valid_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;

    assign master_axi_awid_o     = AXI_ID_WIDTH'(AXI_ID);
    assign master_axi_awaddr_o   = addr_q;
    assign master_axi_awlen_o    = AXI_LEN_SINGLE;
    assign master_axi_awsize_o   = 3'(LOG_NR_BYTES);
    assign master_axi_awburst_o  = AXI_BURST_INCR;
    assign master_axi_awlock_o   = 1'b0;
    assign master_axi_awcache_o  = 4'd0;
    assign master_axi_awprot_o   = 3'd0;
    assign master_axi_awqos_o    = 4'd0;
    assign master_axi_awregion_o = 4'd0;
    assign master_axi_awuser_o   = user_q;
    assign master_axi_awvalid_o  = aw_valid_q;

    assign master_axi_wdata_o    = wdata_q;
    assign master_axi_wstrb_o    = be_q;
    assign master_axi_wlast_o    = 1'b1;
    assign master_axi_wuser_o    = user_q;
    assign master_axi_wvalid_o   = w_valid_q;

    assign master_axi_bready_o   = (state_q == WAIT_B);

    assign master_axi_arid_o     = AXI_ID_WIDTH'(AXI_ID);
    assign master_axi_araddr_o   = addr_q;
    assign master_axi_arlen_o    = AXI_LEN_SINGLE;
    assign master_axi_arsize_o   = 3'(LOG_NR_BYTES);
    assign master_axi_arburst_o  = AXI_BURST_INCR;
    assign master_axi_arlock_o   = 1'b0;
    assign master_axi_arcache_o  = 4'd0;
    assign master_axi_arprot_o   = 3'd0;
    assign master_axi_arqos_o    = 4'd0;
    assign master_axi_arregion_o = 4'd0;
    assign master_axi_aruser_o   = user_q;
    assign master_axi_arvalid_o  = ar_valid_q;

    assign master_axi_rready_o   = (state_q == WAIT_R);

    // Ids are not checked with a single transaction in flight; user bits are ignored.
    logic unused_resp_fields;
    assign unused_resp_fields = ^{master_axi_bid_i, master_axi_buser_i,
                                  master_axi_rid_i, master_axi_ruser_i, master_axi_rlast_i};

    // A read beat without rlast is still taken as the final beat.
    rlast_on_single_beat: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (master_axi_rvalid_i && master_axi_rready_o) |-> master_axi_rlast_i
    );

endmodule

// File: tb/tb_mem2axi.sv
// Self-checking bench for mem2axi: reactive AXI slave model, reference memory and
// an in-order response scoreboard.
module tb_mem2axi;
    import mem2axi_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    logic        req_i = 1'b0, gnt_o, we_i = 1'b0;
    logic [31:0] addr_i = '0, wdata_i = '0;
    logic [3:0]  be_i = '0;
    logic [0:0]  user_i = '0;
    logic        rvalid_o, err_o;
    logic [31:0] rdata_o;

    logic [1:0]  awid, arid;
    logic [31:0] awaddr, araddr, wdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize, awprot, arprot;
    logic [1:0]  awburst, arburst;
    logic        awlock, arlock, awvalid, arvalid, wvalid, wlast, bready, rready;
    logic [3:0]  awcache, arcache, awqos, arqos, awregion, arregion, wstrb;
    logic [0:0]  awuser, aruser, wuser;

    logic        awready = 1'b0, wready = 1'b0, arready = 1'b0;
    logic        bvalid = 1'b0, rvalid = 1'b0, rlast = 1'b0;
    logic [1:0]  bresp = 2'b00, rresp = 2'b00;
    logic [31:0] rdata = '0;

    mem2axi dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_i(req_i), .gnt_o(gnt_o), .we_i(we_i), .addr_i(addr_i), .be_i(be_i),
        .user_i(user_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
        .master_axi_awid_o(awid), .master_axi_awaddr_o(awaddr), .master_axi_awlen_o(awlen),
        .master_axi_awsize_o(awsize), .master_axi_awburst_o(awburst), .master_axi_awlock_o(awlock),
        .master_axi_awcache_o(awcache), .master_axi_awprot_o(awprot), .master_axi_awqos_o(awqos),
        .master_axi_awregion_o(awregion), .master_axi_awuser_o(awuser),
        .master_axi_awvalid_o(awvalid), .master_axi_awready_i(awready),
        .master_axi_wdata_o(wdata), .master_axi_wstrb_o(wstrb), .master_axi_wlast_o(wlast),
        .master_axi_wuser_o(wuser), .master_axi_wvalid_o(wvalid), .master_axi_wready_i(wready),
        .master_axi_bid_i(2'b00), .master_axi_bresp_i(bresp), .master_axi_buser_i(1'b0),
        .master_axi_bvalid_i(bvalid), .master_axi_bready_o(bready),
        .master_axi_arid_o(arid), .master_axi_araddr_o(araddr), .master_axi_arlen_o(arlen),
        .master_axi_arsize_o(arsize), .master_axi_arburst_o(arburst), .master_axi_arlock_o(arlock),
        .master_axi_arcache_o(arcache), .master_axi_arprot_o(arprot), .master_axi_arqos_o(arqos),
        .master_axi_arregion_o(arregion), .master_axi_aruser_o(aruser),
        .master_axi_arvalid_o(arvalid), .master_axi_arready_i(arready),
        .master_axi_rid_i(2'b00), .master_axi_rdata_i(rdata), .master_axi_rresp_i(rresp),
        .master_axi_rlast_i(rlast), .master_axi_ruser_i(1'b0),
        .master_axi_rvalid_i(rvalid), .master_axi_rready_o(rready)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [0:0]  user;
    } req_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    req_t aw_exp_q[$], w_exp_q[$], ar_exp_q[$];
    rsp_t sb_q[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] slv_mem [logic [31:0]];
    logic [31:0] last_rdata = '0;

    int errors = 0;
    int checks = 0;
    int rsp_count = 0;

    int aw_wait = 0, w_wait = 0, ar_wait = 0;
    logic [1:0] bresp_cfg = AXI_RESP_OKAY, rresp_cfg = AXI_RESP_OKAY;
    bit r_hold = 1'b0;

    // Constant AW/AR attributes: id 0, len 0, size 2, INCR, rest zero.
    localparam logic [30:0] ATTR_EXP = {2'd0, 8'd0, 3'd2, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0};

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = data[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    function automatic logic [31:0] slv_rd(input logic [31:0] a);
        return slv_mem.exists(a) ? slv_mem[a] : 32'h0;
    endfunction

    // Slave: handshake capture and field checks on the rising edge.
    req_t aw_e, w_e, ar_e;
    logic [31:0] slv_awaddr = '0, slv_wdata = '0, slv_araddr = '0;
    logic [3:0]  slv_wstrb = '0;
    bit aw_got = 0, w_got = 0, ar_got = 0, b_done = 0, r_done = 0;
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0;

    always @(posedge clk_i) begin
        if (rst_ni) begin
            if (awvalid && awready) begin
                checks++;
                if (aw_exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL aw_unexpected got addr=%h required none", awaddr);
                end else begin
                    aw_e = aw_exp_q.pop_front();
                    if ({awaddr, awuser} !== {aw_e.addr, aw_e.user}) begin
                        errors++;
                        $display("FAIL aw_addr got=%h/%h required=%h/%h", awaddr, awuser, aw_e.addr, aw_e.user);
                    end
                end
                checks++;
                if ({awid, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion} !== ATTR_EXP) begin
                    errors++;
                    $display("FAIL aw_attr got=%h required=%h",
                             {awid, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion}, ATTR_EXP);
                end
                slv_awaddr = awaddr;
                aw_got = 1;
            end
            if (wvalid && wready) begin
                checks++;
                if (w_exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL w_unexpected got data=%h required none", wdata);
                end else begin
                    w_e = w_exp_q.pop_front();
                    if ({wdata, wstrb, wuser, wlast} !== {w_e.wdata, w_e.be, w_e.user, 1'b1}) begin
                        errors++;
                        $display("FAIL w_beat got=%h/%b/%h/%b required=%h/%b/%h/1",
                                 wdata, wstrb, wuser, wlast, w_e.wdata, w_e.be, w_e.user);
                    end
                end
                slv_wdata = wdata;
                slv_wstrb = wstrb;
                w_got = 1;
            end
            if (arvalid && arready) begin
                checks++;
                if (ar_exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL ar_unexpected got addr=%h required none", araddr);
                end else begin
                    ar_e = ar_exp_q.pop_front();
                    if ({araddr, aruser} !== {ar_e.addr, ar_e.user}) begin
                        errors++;
                        $display("FAIL ar_addr got=%h/%h required=%h/%h", araddr, aruser, ar_e.addr, ar_e.user);
                    end
                end
                checks++;
                if ({arid, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion} !== ATTR_EXP) begin
                    errors++;
                    $display("FAIL ar_attr got=%h required=%h",
                             {arid, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion}, ATTR_EXP);
                end
                slv_araddr = araddr;
                ar_got = 1;
            end
            if (bvalid && bready) b_done = 1;
            if (rvalid && rready) r_done = 1;
        end
    end

    // Slave: drives readies and responses on the falling edge.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0; rlast = 0;
            aw_got = 0; w_got = 0; ar_got = 0; b_done = 0; r_done = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        end else begin
            awready = awvalid && (aw_cnt >= aw_wait);
            aw_cnt  = awvalid ? aw_cnt + 1 : 0;
            wready  = wvalid && (w_cnt >= w_wait);
            w_cnt   = wvalid ? w_cnt + 1 : 0;
            arready = arvalid && (ar_cnt >= ar_wait);
            ar_cnt  = arvalid ? ar_cnt + 1 : 0;
            if (b_done) begin bvalid = 0; b_done = 0; end
            if (aw_got && w_got && !bvalid) begin
                bresp = bresp_cfg;
                if (bresp_cfg == AXI_RESP_OKAY)
                    slv_mem[slv_awaddr] = merge(slv_rd(slv_awaddr), slv_wdata, slv_wstrb);
                bvalid = 1; aw_got = 0; w_got = 0;
            end
            if (r_done) begin rvalid = 0; r_done = 0; end
            if (ar_got && !rvalid && !r_hold) begin
                rdata = slv_rd(slv_araddr);
                rresp = rresp_cfg;
                rlast = 1; rvalid = 1; ar_got = 0;
            end
        end
    end

    // Response scoreboard: responses must come back in request order.
    rsp_t sb_e;
    always @(negedge clk_i) begin
        if (rst_ni && rvalid_o) begin
            rsp_count++;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected got rdata=%h err=%b required none", rdata_o, err_o);
            end else begin
                sb_e = sb_q.pop_front();
                if ({rdata_o, err_o} !== {sb_e.rdata, sb_e.err}) begin
                    errors++;
                    $display("FAIL rsp got rdata=%h err=%b required rdata=%h err=%b",
                             rdata_o, err_o, sb_e.rdata, sb_e.err);
                end
            end
        end
    end

    // Drives one request and waits for its grant; returns at the falling edge after the grant.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd, input logic [0:0] user, input bit hold);
        int   n;
        req_t r;
        rsp_t s;
        req_i = 1'b1; we_i = we; addr_i = addr; be_i = be; wdata_i = wd; user_i = user;
        n = 0;
        #1;
        while (!gnt_o && n < 100) begin
            @(negedge clk_i); #1; n++;
        end
        checks++;
        if (!gnt_o) begin
            errors++;
            $display("FAIL grant_timeout got gnt_o=0 after %0d cycles required 1", n);
            req_i = 1'b0;
            return;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL grant_not_idle got outstanding=%0d required 0", sb_q.size());
        end
        r = '{addr, be, wd, user};
        if (we) begin
            aw_exp_q.push_back(r);
            w_exp_q.push_back(r);
            s.err   = (bresp_cfg != AXI_RESP_OKAY);
            s.rdata = last_rdata;
            if (!s.err) ref_mem[addr] = merge(ref_rd(addr), wd, be);
        end else begin
            ar_exp_q.push_back(r);
            s.err      = (rresp_cfg != AXI_RESP_OKAY);
            s.rdata    = ref_rd(addr);
            last_rdata = s.rdata;
        end
        sb_q.push_back(s);
        @(posedge clk_i);
        @(negedge clk_i);
        if (!hold) req_i = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk_i); n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain got pending=%0d required 0", name, sb_q.size());
            sb_q.delete();
        end
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        req_i = 1'b1;
        repeat (3) @(negedge clk_i);
        #1;
        checks++;
        if (gnt_o !== 1'b0) begin errors++; $display("FAIL reset_gnt got=%b required 0", gnt_o); end
        checks++;
        if ({awvalid, wvalid, arvalid, bready, rready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_axi got=%b required 00000", {awvalid, wvalid, arvalid, bready, rready});
        end
        checks++;
        if ({rvalid_o, err_o, rdata_o} !== 34'h0) begin
            errors++;
            $display("FAIL reset_rsp got=%b/%b/%h required 0/0/0", rvalid_o, err_o, rdata_o);
        end
        @(negedge clk_i);
        req_i  = 1'b0;
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_read_zero_wait();
        int n;
        ref_mem[32'h100] = 32'hDEADBEEF;
        slv_mem[32'h100] = 32'hDEADBEEF;
        issue(1'b0, 32'h100, 4'hF, 32'h0, 1'b0, 1'b0);
        #1;
        checks++;
        if ({arvalid, araddr, arsize} !== {1'b1, 32'h100, 3'd2}) begin
            errors++;
            $display("FAIL read_ar got=%b/%h/%0d required 1/00000100/2", arvalid, araddr, arsize);
        end
        n = 1;
        while (!rvalid_o && n < 20) begin
            @(negedge clk_i); #1; n++;
        end
        checks++;
        if (n != 3) begin errors++; $display("FAIL read_latency got=%0d required 3", n); end
        @(negedge clk_i); #1;
        checks++;
        if (rvalid_o !== 1'b0) begin errors++; $display("FAIL read_pulse got=%b required 0", rvalid_o); end
        wait_drain("read");
    endtask

    task automatic test_write_w_first();
        aw_wait = 2; w_wait = 0;
        ref_mem[32'h40] = 32'h12345678;
        slv_mem[32'h40] = 32'h12345678;
        issue(1'b1, 32'h40, 4'b0011, 32'hA5A5A5A5, 1'b1, 1'b0);
        #1;
        checks++;
        if ({awvalid, wvalid} !== 2'b11) begin
            errors++; $display("FAIL wfirst_c1 got aw/w=%b required 11", {awvalid, wvalid});
        end
        @(negedge clk_i); #1;
        checks++;
        if ({awvalid, wvalid, awaddr} !== {2'b10, 32'h40}) begin
            errors++; $display("FAIL wfirst_c2 got aw/w=%b addr=%h required 10/00000040", {awvalid, wvalid}, awaddr);
        end
        @(negedge clk_i); #1;
        checks++;
        if ({awvalid, bready} !== 2'b10) begin
            errors++; $display("FAIL wfirst_c3 got aw/bready=%b required 10", {awvalid, bready});
        end
        @(negedge clk_i); #1;
        checks++;
        if ({awvalid, bready} !== 2'b01) begin
            errors++; $display("FAIL wfirst_c4 got aw/bready=%b required 01", {awvalid, bready});
        end
        wait_drain("wfirst");
        aw_wait = 0;
        issue(1'b0, 32'h40, 4'hF, 32'h0, 1'b1, 1'b0);
        wait_drain("wfirst_readback");
    endtask

    task automatic test_backpressure();
        ar_wait = 5;
        ref_mem[32'h200] = 32'hCAFEF00D;
        slv_mem[32'h200] = 32'hCAFEF00D;
        issue(1'b0, 32'h200, 4'hF, 32'h0, 1'b0, 1'b0);
        req_i = 1'b1; we_i = 1'b1; addr_i = 32'h204; be_i = 4'hF; wdata_i = 32'h0BADF00D;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ({arvalid, araddr, gnt_o} !== {1'b1, 32'h200, 1'b0}) begin
                errors++;
                $display("FAIL bp_cycle%0d got ar=%b addr=%h gnt=%b required 1/00000200/0", i, arvalid, araddr, gnt_o);
            end
            @(negedge clk_i);
        end
        issue(1'b1, 32'h204, 4'hF, 32'h0BADF00D, 1'b0, 1'b0);
        wait_drain("bp");
        ar_wait = 0;
    endtask

    task automatic test_error();
        bresp_cfg = AXI_RESP_SLVERR;
        issue(1'b1, 32'h300, 4'hF, 32'hFFFFFFFF, 1'b0, 1'b0);
        wait_drain("err_write");
        checks++;
        if (err_o !== 1'b1) begin errors++; $display("FAIL err_hold got=%b required 1", err_o); end
        bresp_cfg = AXI_RESP_OKAY;
        issue(1'b0, 32'h204, 4'hF, 32'h0, 1'b0, 1'b0);
        wait_drain("err_read");
        checks++;
        if (err_o !== 1'b0) begin errors++; $display("FAIL err_clear got=%b required 0", err_o); end
    endtask

    task automatic test_back_to_back();
        int base;
        base = rsp_count;
        issue(1'b1, 32'h300, 4'hF,    32'h11223344, 1'b1, 1'b1);
        issue(1'b0, 32'h300, 4'hF,    32'h0,        1'b0, 1'b1);
        issue(1'b1, 32'h300, 4'b0101, 32'hAABBCCDD, 1'b0, 1'b1);
        issue(1'b0, 32'h300, 4'hF,    32'h0,        1'b1, 1'b0);
        wait_drain("b2b");
        checks++;
        if (rsp_count - base != 4) begin
            errors++; $display("FAIL b2b_count got=%0d required 4", rsp_count - base);
        end
    endtask

    task automatic test_reset_mid_read();
        r_hold = 1'b1;
        ref_mem[32'h500] = 32'h5A5A0F0F;
        slv_mem[32'h500] = 32'h5A5A0F0F;
        issue(1'b0, 32'h500, 4'hF, 32'h0, 1'b0, 1'b0);
        repeat (2) @(negedge clk_i);
        #1;
        checks++;
        if (rready !== 1'b1) begin errors++; $display("FAIL midrst_wait_r got rready=%b required 1", rready); end
        req_i  = 1'b1;
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({awvalid, wvalid, arvalid, bready, rready, gnt_o} !== 6'b0) begin
            errors++;
            $display("FAIL midrst_axi got=%b required 000000", {awvalid, wvalid, arvalid, bready, rready, gnt_o});
        end
        checks++;
        if ({rvalid_o, err_o, rdata_o} !== 34'h0) begin
            errors++;
            $display("FAIL midrst_rsp got=%b/%b/%h required 0/0/0", rvalid_o, err_o, rdata_o);
        end
        sb_q.delete(); aw_exp_q.delete(); w_exp_q.delete(); ar_exp_q.delete();
        last_rdata = '0;
        r_hold = 1'b0;
        repeat (2) @(negedge clk_i);
        req_i  = 1'b0;
        rst_ni = 1'b1;
        @(negedge clk_i);
        issue(1'b0, 32'h500, 4'hF, 32'h0, 1'b0, 1'b0);
        wait_drain("midrst_read");
    endtask

    initial begin
        test_reset();
        test_read_zero_wait();
        test_write_w_first();
        test_backpressure();
        test_error();
        test_back_to_back();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish required finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
